// File: rtl/argmax_sequencer.sv
// argmax_sequencer: front-end controller for the argmax_cell chain at the network output.
// Accepts CLASS_AMOUNT scores over valid/ready and forwards each score with its index to
// the chain. It then waits for the chain's valid-flagged result and presents the winning
// index to the consumer over valid/ready.
// Optional build macro: ARGMAX_TIMEOUT_EN adds a WAIT-state timeout of RESULT_TIMEOUT
// cycles. On timeout, an all-ones index and the error flag are reported.
module argmax_sequencer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CLASS_AMOUNT   = 10,
  parameter int unsigned RESULT_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_value,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] argmax_index,
  output logic [DATA_WIDTH-1:0] argmax_value,
  output logic                  argmax_enable,
  input  logic [DATA_WIDTH:0]   argmax_result,
  output logic [DATA_WIDTH-1:0] result_index,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy,
  output logic                  error
);

  localparam int unsigned CW = (CLASS_AMOUNT > 1) ? $clog2(CLASS_AMOUNT) : 1;
  localparam logic [CW-1:0]         LAST_COUNT  = CW'(CLASS_AMOUNT - 1);
  localparam logic [DATA_WIDTH-1:0] CLASS_LIMIT = DATA_WIDTH'(CLASS_AMOUNT);

  localparam logic [1:0] ST_FEED = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Reject configurations with no meaningful vector or timeout length.
  if (CLASS_AMOUNT < 2 || RESULT_TIMEOUT < 1) begin : g_bad_params
    $error("argmax_sequencer: CLASS_AMOUNT must be >= 2 and RESULT_TIMEOUT >= 1");
  end

  logic [1:0]            r_state;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_index;
  logic [DATA_WIDTH-1:0] r_value;
  logic                  r_enable;
  logic [DATA_WIDTH-1:0] r_res_index;
  logic                  r_res_valid;
  logic                  r_error;

  logic                  w_xfer;
  logic                  w_chain_valid;
  logic [DATA_WIDTH-1:0] w_chain_index;
  logic                  w_timeout;

  // in_ready is held low during reset so that every output reads 0 while rst is high.
  assign in_ready      = (r_state == ST_FEED) && !rst;
  assign w_xfer        = in_ready && in_valid;
  assign w_chain_valid = argmax_result[DATA_WIDTH];
  assign w_chain_index = argmax_result[DATA_WIDTH-1:0];

`ifdef ARGMAX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(RESULT_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(RESULT_TIMEOUT - 1);

  logic [TW-1:0] r_timer;

  // WAIT-cycle timer: zero on the first WAIT cycle, reset whenever the FSM is elsewhere.
  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_WAIT)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // Fires on the RESULT_TIMEOUT-th WAIT cycle; a valid result that cycle takes priority.
  assign w_timeout = (r_state == ST_WAIT) && (r_timer == TIMER_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // Main FSM: feed the scores, await the chain result, then hold it for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FEED;
      r_count     <= '0;
      r_index     <= '0;
      r_value     <= '0;
      r_enable    <= 1'b0;
      r_res_index <= '0;
      r_res_valid <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_enable <= 1'b0;
      case (r_state)
        ST_FEED: begin
          if (w_xfer) begin
            r_value  <= in_value;
            r_index  <= DATA_WIDTH'(r_count);
            r_enable <= 1'b1;
            if (r_count == LAST_COUNT) begin
              r_count <= '0;
              r_state <= ST_WAIT;
            end else begin
              r_count <= r_count + CW'(1);
            end
          end
        end
        ST_WAIT: begin
          if (w_chain_valid) begin
            r_res_index <= w_chain_index;
            r_res_valid <= 1'b1;
            r_state     <= ST_HOLD;
            // Out-of-range winner is still presented, but flagged.
            if (w_chain_index >= CLASS_LIMIT) begin
              r_error <= 1'b1;
            end
          end else if (w_timeout) begin
            r_res_index <= '1;
            r_res_valid <= 1'b1;
            r_error     <= 1'b1;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (result_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_FEED;
          end
        end
        default: r_state <= ST_FEED;
      endcase
    end
  end

  assign argmax_index  = r_index;
  assign argmax_value  = r_value;
  assign argmax_enable = r_enable;
  assign result_index  = r_res_index;
  assign result_valid  = r_res_valid;
  assign error         = r_error;
  assign busy          = (r_state != ST_FEED) || (r_count != '0);

endmodule

// File: tb/tb_argmax_sequencer.sv
// Self-checking bench for argmax_sequencer (CLASS_AMOUNT=4, RESULT_TIMEOUT=8).
// A behavioural model predicts every output each cycle from the handshake rules; the bench
// plays the argmax chain and replies with the first-maximum index (or chosen values).
// Define ARGMAX_TIMEOUT_EN for both RTL and bench to exercise the timeout build.
module tb_argmax_sequencer;

  localparam int DW = 32;
  localparam int CA = 4;
  localparam int RT = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_value = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] argmax_index;
  logic [DW-1:0] argmax_value;
  logic          argmax_enable;
  logic [DW:0]   argmax_result = '0;
  logic [DW-1:0] result_index;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic          busy;
  logic          error;

  argmax_sequencer #(
    .DATA_WIDTH    (DW),
    .CLASS_AMOUNT  (CA),
    .RESULT_TIMEOUT(RT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_value     (in_value),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .argmax_index (argmax_index),
    .argmax_value (argmax_value),
    .argmax_enable(argmax_enable),
    .argmax_result(argmax_result),
    .result_index (result_index),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .error        (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = collecting scores, 1 = awaiting chain, 2 = presenting.
  int            m_phase, m_count, m_wait;
  bit            m_live = 1'b0;
  bit            m_en, m_rv, m_err;
  logic [DW-1:0] m_idx, m_val, m_ridx;
  logic [DW-1:0] vec [CA];

  task automatic compare_all();
    check("in_ready", 64'(in_ready), 64'(!rst && m_phase == 0));
    check("argmax_enable", 64'(argmax_enable), 64'(m_en));
    check("argmax_index", 64'(argmax_index), 64'(m_idx));
    check("argmax_value", 64'(argmax_value), 64'(m_val));
    check("result_valid", 64'(result_valid), 64'(m_rv));
    check("result_index", 64'(result_index), 64'(m_ridx));
    check("busy", 64'(busy), 64'(m_phase != 0 || m_count != 0));
    check("error", 64'(error), 64'(m_err));
  endtask

  // Advance one clock, update the model from the inputs seen at the edge, then compare.
  task automatic tick();
    bit            r, iv, rr;
    logic [DW-1:0] ival;
    logic [DW:0]   ar;
    r = rst; iv = in_valid; rr = result_ready; ival = in_value; ar = argmax_result;
    @(posedge clk);
    #1;
    if (r) begin
      m_phase = 0; m_count = 0; m_wait = 0;
      m_en = 0; m_rv = 0; m_err = 0;
      m_idx = '0; m_val = '0; m_ridx = '0;
      m_live = 1'b1;
    end else if (m_live) begin
      m_en = 0;
      case (m_phase)
        0: if (iv) begin
          m_en = 1; m_val = ival; m_idx = DW'(m_count);
          m_count++;
          if (m_count == CA) begin
            m_count = 0; m_phase = 1; m_wait = 0;
          end
        end
        1: begin
          if (ar[DW]) begin
            m_ridx = ar[DW-1:0]; m_rv = 1; m_phase = 2;
            if (m_ridx >= CA) m_err = 1;
          end else begin
`ifdef ARGMAX_TIMEOUT_EN
            if (m_wait == RT - 1) begin
              m_ridx = '1; m_rv = 1; m_err = 1; m_phase = 2;
            end else m_wait++;
`else
            m_wait++;
`endif
          end
        end
        default: if (rr) begin
          m_rv = 0; m_phase = 0;
        end
      endcase
    end
    if (m_live) compare_all();
  endtask

  function automatic logic [DW-1:0] ref_argmax();
    logic [DW-1:0] best = vec[0];
    logic [DW-1:0] bi = '0;
    for (int i = 1; i < CA; i++) if (vec[i] > best) begin
      best = vec[i]; bi = DW'(i);
    end
    return bi;
  endfunction

  task automatic feed(input int gap_after, input int gap_len, input bit stray);
    for (int i = 0; i < CA; i++) begin
      if (i == gap_after + 1 && gap_len > 0) begin
        in_valid = 1'b0;
        repeat (gap_len) tick();
      end
      in_valid = 1'b1;
      in_value = vec[i];
      argmax_result = (stray && i == 1) ? {1'b1, 32'd2} : '0;
      tick();
    end
    in_valid = 1'b0;
    argmax_result = '0;
    in_value = $urandom;
  endtask

  task automatic run_vector(input int gap_after, input int gap_len, input bit stray,
                            input logic [DW-1:0] reply, input int delay, input int hold,
                            input bit valid_on_release);
    feed(gap_after, gap_len, stray);
    repeat (delay) tick();
    argmax_result = {1'b1, reply};
    tick();
    argmax_result = '0;
    repeat (hold) tick();
    result_ready = 1'b1;
    in_valid = valid_on_release;
    in_value = 32'hdead_beef;
    tick();
    result_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic set_vec(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [DW-1:0] d);
    vec[0] = a; vec[1] = b; vec[2] = c; vec[3] = d;
  endtask

  initial begin
    int first;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Back-to-back vector, result held 3 cycles, consumer also offers a score on release.
    set_vec(5, 9, 2, 7);
    run_vector(-1, 0, 1'b0, 32'd1, 0, 3, 1'b1);
    tick();
    // Two-cycle gap after the second score.
    run_vector(1, 2, 1'b0, 32'd1, 1, 1, 1'b0);
    // Valid bit during feeding must be ignored.
    run_vector(-1, 0, 1'b1, 32'd3, 2, 0, 1'b0);

    // Randomised vectors with chain-like replies.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < CA; i++) vec[i] = (n % 3 == 0) ? 32'd42 : $urandom;
      run_vector(int'($urandom_range(0, 3)) - 1, int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ref_argmax(), int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Out-of-range winner sets a sticky error that survives the next vector.
    set_vec(1, 2, 3, 4);
    run_vector(-1, 0, 1'b0, 32'd6, 0, 1, 1'b0);
    check("error_after_bad_index", 64'(error), 64'd1);
    run_vector(-1, 0, 1'b0, ref_argmax(), 1, 0, 1'b0);
    check("error_sticky", 64'(error), 64'd1);

    // Reset after two scores of a vector.
    in_valid = 1'b1;
    in_value = 32'd11; tick();
    in_value = 32'd12; tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("error_cleared", 64'(error), 64'd0);
    set_vec(3, 8, 8, 1);
    run_vector(-1, 0, 1'b0, ref_argmax(), 0, 2, 1'b0);

    // Chain never replies.
    set_vec(7, 7, 7, 7);
    feed(-1, 0, 1'b0);
    first = -1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (result_valid === 1'b1 && first < 0) first = k;
    end
`ifdef ARGMAX_TIMEOUT_EN
    check("timeout_latency", 64'(first), 64'(RT));
    check("timeout_index", 64'(result_index), 64'(32'hffff_ffff));
    check("timeout_error", 64'(error), 64'd1);
`else
    check("no_reply_stays_idle", 64'(first), 64'(-1));
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    set_vec(0, 0, 100, 5);
    run_vector(-1, 0, 1'b0, ref_argmax(), 0, 0, 1'b0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
